// File: rtl/hilo_muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide engine.
// The build macro FAST_MUL_EN (see hilo_muldiv_unit.sv) selects a single-cycle multiply.
package hilo_muldiv_pkg;

  localparam logic [1:0] OP_MULTU = 2'b00;
  localparam logic [1:0] OP_MULT  = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_DIV   = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int iter_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int ITER_W = iter_w(32);

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle between the EX-stage control and the HI/LO engine.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (output start, op, X, Y, mthi, mtlo,
                  input  hi, lo, busy, done, div_by_zero);
  modport slave  (input  start, op, X, Y, mthi, mtlo,
                  output hi, lo, busy, done, div_by_zero);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the engine: shift-add multiply or restoring divide,
// both operating on a 2*WIDTH accumulator split into hi/lo halves.
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             div_i,
  input  logic [WIDTH-1:0] acc_hi_i,
  input  logic [WIDTH-1:0] acc_lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_hi_o,
  output logic [WIDTH-1:0] acc_lo_o
);
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  always_comb begin
    sum   = {1'b0, acc_hi_i} + (acc_lo_i[0] ? {1'b0, opnd_i} : '0);
    // remainder shifted left with the next dividend bit pulled in
    trial = {acc_hi_i, acc_lo_i[WIDTH-1]};
    diff  = trial[WIDTH-1:0] - opnd_i;
    if (div_i) begin
      if (trial >= {1'b0, opnd_i}) begin
        acc_hi_o = diff;
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_hi_o = trial[WIDTH-1:0];
        acc_lo_o = {acc_lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_hi_o = sum[WIDTH:1];
      acc_lo_o = {sum[0], acc_lo_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the architectural HI/LO registers.
// Define FAST_MUL_EN to compute products in a single cycle (divide stays iterative).
module hilo_muldiv_unit
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  hilo_muldiv_unit_if.slave bus
);
  localparam int             CW   = iter_w(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d, opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             sx_q, sx_d, sy_q, sy_d, dbz_q, dbz_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic               sgn_x, sgn_y;
  logic [WIDTH-1:0]   abs_x, abs_y, step_hi, step_lo, quo_s, rem_s;
  logic [2*WIDTH-1:0] prod, prod_s;

  assign sgn_x = bus.op[0] & bus.X[WIDTH-1];
  assign sgn_y = bus.op[0] & bus.Y[WIDTH-1];
  assign abs_x = sgn_x ? -bus.X : bus.X;
  assign abs_y = sgn_y ? -bus.Y : bus.Y;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div_i    (op_q[1]),
    .acc_hi_i (acc_hi_q),
    .acc_lo_i (acc_lo_q),
    .opnd_i   (opnd_q),
    .acc_hi_o (step_hi),
    .acc_lo_o (step_lo)
  );

  // Sign fix-up; the quotient negation wraps naturally for MIN / -1.
  assign prod   = {acc_hi_q, acc_lo_q};
  assign prod_s = (sx_q ^ sy_q) ? -prod : prod;
  assign quo_s  = (sx_q ^ sy_q) ? -acc_lo_q : acc_lo_q;
  assign rem_s  = sx_q ? -acc_hi_q : acc_hi_q;

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, abs_x} * {{WIDTH{1'b0}}, abs_y};
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    dbz_d    = dbz_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          sx_d     = sgn_x;
          sy_d     = sgn_y;
          dbz_d    = 1'b0;
          cnt_d    = '0;
          acc_hi_d = '0;
          if (bus.op[1]) begin
            acc_lo_d = abs_x;
            opnd_d   = abs_y;
            if (bus.Y == '0) begin
              // raw dividend parked in acc_hi for the FIX writeback
              dbz_d    = 1'b1;
              acc_hi_d = bus.X;
              state_d  = FIX;
            end else begin
              state_d  = CALC;
            end
          end else begin
`ifdef FAST_MUL_EN
            {acc_hi_d, acc_lo_d} = fast_prod;
            state_d  = FIX;
`else
            acc_lo_d = abs_y;
            opnd_d   = abs_x;
            state_d  = CALC;
`endif
          end
        end else begin
          if (bus.mthi) hi_d = bus.X;
          if (bus.mtlo) lo_d = bus.X;
        end
      end
      CALC: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: begin
        if (dbz_q) begin
          hi_d = acc_hi_q;
          lo_d = '1;
        end else if (op_q[1]) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end else begin
          {hi_d, lo_d} = prod_s;
        end
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      dbz_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      dbz_q    <= dbz_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.busy        = (state_q == CALC) || (state_q == FIX);
  assign bus.done        = (state_q == DONE);
  assign bus.div_by_zero = dbz_q;

endmodule
